// File: rtl/data_ram_pkg.sv
// data_ram_pkg: shared widths, FSM state encoding and enable constants for data_ram
package data_ram_pkg;
  localparam int WORD_W = 32;
  localparam int SEL_W = 4;
  localparam logic ENABLE = 1'b1;
  localparam logic DISABLE = 1'b0;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RESPOND = 2'd2
  } state_e;
endpackage

// File: rtl/ram_bank.sv
// ram_bank: byte-lane word storage with per-byte write enables and a registered read port
module ram_bank
  import data_ram_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic              clk,
  input  logic [SEL_W-1:0]  we_i,
  input  logic              re_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o
);
  logic [WORD_W-1:0] mem_q [2**AW];
  logic [WORD_W-1:0] rdata_q;
  always_ff @(posedge clk) begin
    for (int i = 0; i < SEL_W; i++)
      if (we_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
    if (re_i) rdata_q <= mem_q[addr_i];
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/data_ram.sv
// data_ram: memory-stage bus responder with programmable wait states and out-of-range error
module data_ram
  import data_ram_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              request,
  input  logic              write,
  input  logic [31:0]       address,
  input  logic [SEL_W-1:0]  select,
  input  logic [WORD_W-1:0] write_data,
  output logic [WORD_W-1:0] read_data,
  output logic              ready,
  output logic              error
);
  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic write_q, ready_q, error_q, valid_q;
  logic [31:0] addr_q;
  logic [SEL_W-1:0] sel_q;
  logic [WORD_W-1:0] wdata_q, bank_rdata;
  logic accept, respond, in_range;
  assign accept = state_q == ST_IDLE && request;
  assign respond = state_q == ST_RESPOND;
  assign in_range = ~|(addr_q >> (ADDRESS_WIDTH + 2));
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    case (state_q)
      ST_IDLE: if (request) begin
        state_d = WAIT_CYCLES > 0 ? ST_WAIT : ST_RESPOND;
        cnt_d = 4'(WAIT_CYCLES);
      end
      ST_WAIT: begin
        state_d = !request ? ST_IDLE : cnt_q <= 4'd1 ? ST_RESPOND : ST_WAIT;
        cnt_d = cnt_q - 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  // valid_q masks the bank's read register so reset and out-of-range loads read as zero
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      ready_q <= 1'b0;
      error_q <= 1'b0;
      valid_q <= 1'b0;
      write_q <= 1'b0;
      addr_q <= '0;
      sel_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ready_q <= respond;
      error_q <= respond && !in_range;
      if (respond && !write_q) valid_q <= in_range;
      if (accept) begin
        write_q <= write;
        addr_q <= address;
        sel_q <= select;
        wdata_q <= write_data;
      end
    end
  end
  ram_bank #(.AW(ADDRESS_WIDTH)) u_bank (
    .clk     (clock),
    .we_i    (respond && write_q && in_range ? sel_q : '0),
    .re_i    (respond && !write_q && in_range ? ENABLE : DISABLE),
    .addr_i  (addr_q[ADDRESS_WIDTH+1:2]),
    .wdata_i (wdata_q),
    .rdata_o (bank_rdata)
  );
  assign read_data = valid_q ? bank_rdata : '0;
  assign ready = ready_q;
  assign error = error_q;
endmodule

// File: tb/tb_data_ram.sv
// tb_data_ram: directed + random checks of data_ram (WAIT_CYCLES 1 and 0) against a word-array model
module tb_data_ram;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic        req [2];
  logic        wr [2];
  logic [31:0] addr [2];
  logic [3:0]  sel [2];
  logic [31:0] wd [2];
  logic [31:0] rd [2];
  logic        rdy [2];
  logic        er [2];
  int checks = 0;
  int failures = 0;
  logic [31:0] mem_m [2][1024];
  logic [31:0] last_rd [2];
  int p1, p2, n;

  always #5 clock = ~clock;

  data_ram #(.ADDRESS_WIDTH(10), .WAIT_CYCLES(1)) dut (
    .clock(clock), .reset(reset), .request(req[1]), .write(wr[1]), .address(addr[1]),
    .select(sel[1]), .write_data(wd[1]), .read_data(rd[1]), .ready(rdy[1]), .error(er[1])
  );
  data_ram #(.ADDRESS_WIDTH(10), .WAIT_CYCLES(0)) dut0 (
    .clock(clock), .reset(reset), .request(req[0]), .write(wr[0]), .address(addr[0]),
    .select(sel[0]), .write_data(wd[0]), .read_data(rd[0]), .ready(rdy[0]), .error(er[0])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete access on instance u (whose WAIT_CYCLES equals u); inputs are scrambled after acceptance
  task automatic op(input int u, input bit w, input logic [31:0] a, input logic [3:0] s,
                    input logic [31:0] d, input string tag);
    int lat;
    bit ok;
    logic [31:0] got;
    logic e;
    lat = -1;
    ok = a < 32'h1000;
    @(negedge clock);
    req[u] = 1'b1; wr[u] = w; addr[u] = a; sel[u] = s; wd[u] = d;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      if (rdy[u]) begin
        lat = k;
        break;
      end
      wr[u] = 1'($urandom); addr[u] = $urandom; sel[u] = 4'($urandom); wd[u] = $urandom;
    end
    got = rd[u];
    e = er[u];
    req[u] = 1'b0;
    if (w && ok)
      for (int i = 0; i < 4; i++) if (s[i]) mem_m[u][a[11:2]][8*i +: 8] = d[8*i +: 8];
    if (!w) last_rd[u] = ok ? mem_m[u][a[11:2]] : 32'h0;
    chk({tag, " latency"}, 32'(lat), 32'(u + 2));
    chk({tag, " error"}, {31'h0, e}, {31'h0, !ok});
    chk({tag, " read_data"}, got, last_rd[u]);
    @(negedge clock);
    chk({tag, " pulse"}, {31'h0, rdy[u]}, 32'h0);
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      req[u] = 1'b0; wr[u] = 1'b0; addr[u] = '0; sel[u] = '0; wd[u] = '0; last_rd[u] = '0;
    end
    #20 reset = 1'b0;
    repeat (10) begin
      @(negedge clock);
      chk("idle ready", {31'h0, rdy[1]}, 32'h0);
      chk("idle error", {31'h0, er[1]}, 32'h0);
      chk("idle read_data", rd[1], 32'h0);
    end
    chk("idle0 ready", {31'h0, rdy[0]}, 32'h0);
    for (int i = 0; i < 32; i++) op(1, 1'b1, 32'(i * 4), 4'hF, $urandom, "init");
    for (int i = 0; i < 4; i++) op(0, 1'b1, 32'(i * 4), 4'hF, $urandom, "init0");
    op(1, 1'b1, 32'h10, 4'hF, 32'h00005564, "st10");
    op(1, 1'b0, 32'h10, 4'h0, 32'h0, "ld10");
    chk("ld10 const", rd[1], 32'h00005564);
    op(1, 1'b1, 32'h20, 4'hF, 32'h11223344, "st20 full");
    op(1, 1'b1, 32'h20, 4'b0101, 32'hAABBCCDD, "st20 merge");
    op(1, 1'b0, 32'h20, 4'h1, 32'h0, "ld20");
    chk("ld20 const", rd[1], 32'h11BB33DD);
    op(1, 1'b0, 32'h1000, 4'hF, 32'h0, "ld oor");
    chk("ld oor const", rd[1], 32'h0);
    op(1, 1'b1, 32'h1000, 4'hF, 32'h5A5A5A5A, "st oor");
    op(1, 1'b0, 32'h0, 4'hF, 32'h0, "ld word0");
    @(negedge clock);
    req[1] = 1'b1; wr[1] = 1'b1; addr[1] = 32'h30; sel[1] = 4'hF; wd[1] = 32'hCAFEF00D;
    @(negedge clock);
    req[1] = 1'b0;
    n = 0;
    repeat (5) begin
      @(negedge clock);
      if (rdy[1]) n++;
    end
    chk("abort ready count", 32'(n), 32'h0);
    op(1, 1'b0, 32'h30, 4'hF, 32'h0, "ld30 after abort");
    op(1, 1'b0, 32'h10, 4'hF, 32'h0, "ld10 pre-reset");
    @(negedge clock);
    req[1] = 1'b1; wr[1] = 1'b1; addr[1] = 32'h40; sel[1] = 4'hF; wd[1] = 32'hDEADBEEF;
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("midreset ready", {31'h0, rdy[1]}, 32'h0);
    chk("midreset read_data", rd[1], 32'h0);
    last_rd[1] = 32'h0;
    last_rd[0] = 32'h0;
    req[1] = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("postreset ready", {31'h0, rdy[1]}, 32'h0);
    op(1, 1'b0, 32'h40, 4'hF, 32'h0, "ld40 after reset");
    op(0, 1'b1, 32'h8, 4'hF, 32'h12345678, "z st8");
    op(0, 1'b0, 32'h8, 4'h0, 32'h0, "z ld8");
    chk("z ld8 const", rd[0], 32'h12345678);
    op(0, 1'b1, 32'h8, 4'h0, 32'hFFFFFFFF, "z st8 nosel");
    op(0, 1'b0, 32'h8, 4'h0, 32'h0, "z ld8 again");
    @(negedge clock);
    req[1] = 1'b1; wr[1] = 1'b0; addr[1] = 32'h10; sel[1] = 4'hF;
    p1 = 0;
    p2 = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      if (rdy[1]) begin
        if (p1 == 0) p1 = k;
        else if (p2 == 0) p2 = k;
      end
    end
    req[1] = 1'b0;
    repeat (4) @(negedge clock);
    chk("b2b first ready", 32'(p1), 32'd3);
    chk("b2b second ready", 32'(p2), 32'd6);
    last_rd[1] = mem_m[1][4];
    repeat (60) begin
      logic [31:0] a;
      if ($urandom_range(0, 5) == 0)
        a = (32'h1000 << $urandom_range(0, 19)) | 32'($urandom_range(0, 4095));
      else
        a = {20'h0, 5'($urandom_range(0, 31)), 5'h0, 2'($urandom)};
      op(1, 1'($urandom), a, 4'($urandom), $urandom, "rand");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
